// File: rtl/svm_mem_responder.sv
// Avalon-MM burst responder that terminates the kernel SVM port on an on-chip RAM.
// Accepts burst writes/reads, returns read bursts at fixed latency, counts protocol errors.
module svm_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 48,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 5,
  parameter int unsigned MEM_DEPTH_LOG2  = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic                       read,
  input  logic                       write,
  input  logic [BURST_CNT_WIDTH-1:0] burstcount,
  input  logic [DATA_WIDTH-1:0]      writedata,
  input  logic [DATA_WIDTH/8-1:0]    byteenable,
  output logic                       waitrequest,
  output logic [DATA_WIDTH-1:0]      readdata,
  output logic                       readdatavalid,
  output logic [15:0]                err_count
);

  localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SEL   = $clog2(DATA_BYTES);
  localparam int unsigned MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR_BURST = 2'd1;
  localparam logic [1:0] S_RD_BURST = 2'd2;

  logic [DATA_WIDTH-1:0]      r_mem [MEM_DEPTH];
  logic [1:0]                 r_state;
  logic [BURST_CNT_WIDTH-1:0] r_remaining;
  logic [MEM_DEPTH_LOG2-1:0]  r_index;
  logic                       r_waitrequest;
  logic                       r_readdatavalid;
  logic [DATA_WIDTH-1:0]      r_readdata;
  logic [15:0]                r_err_count;

  logic [1:0]                 w_state_nxt;
  logic [BURST_CNT_WIDTH-1:0] w_remaining_nxt;
  logic [MEM_DEPTH_LOG2-1:0]  w_index_nxt;
  logic [MEM_DEPTH_LOG2-1:0]  w_addr_idx;
  logic [MEM_DEPTH_LOG2-1:0]  w_mem_idx;
  logic                       w_mem_we;
  logic                       w_rd_issue;
  logic                       w_err_inc;
  logic                       w_accept;
  logic                       w_unused_addr;

  // Upper bits alias modulo the RAM size; sub-word bits select nothing.
  assign w_addr_idx    = address[BYTE_SEL +: MEM_DEPTH_LOG2];
  assign w_unused_addr = ^{address[ADDR_WIDTH-1:BYTE_SEL+MEM_DEPTH_LOG2], address[BYTE_SEL-1:0]};
  assign w_accept      = (read | write) & ~r_waitrequest;

  // Next-state, RAM control and error detection.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_index_nxt     = r_index;
    w_mem_idx       = r_index;
    w_mem_we        = 1'b0;
    w_rd_issue      = 1'b0;
    w_err_inc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (burstcount == '0) begin
            w_err_inc = 1'b1;
          end else if (write) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = w_addr_idx;
            w_index_nxt = w_addr_idx + 1'b1;
            w_err_inc   = read;
            if (burstcount != BURST_CNT_WIDTH'(1)) begin
              w_state_nxt     = S_WR_BURST;
              w_remaining_nxt = burstcount - 1'b1;
            end
          end else begin
            w_state_nxt     = S_RD_BURST;
            w_index_nxt     = w_addr_idx;
            w_remaining_nxt = burstcount;
          end
        end
      end
      S_WR_BURST: begin
        w_err_inc = read;
        if (write) begin
          w_mem_we        = 1'b1;
          w_index_nxt     = r_index + 1'b1;
          w_remaining_nxt = r_remaining - 1'b1;
          if (r_remaining == BURST_CNT_WIDTH'(1)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RD_BURST: begin
        w_rd_issue      = 1'b1;
        w_index_nxt     = r_index + 1'b1;
        w_remaining_nxt = r_remaining - 1'b1;
        if (r_remaining == BURST_CNT_WIDTH'(1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_remaining     <= '0;
      r_index         <= '0;
      r_waitrequest   <= 1'b1;
      r_readdatavalid <= 1'b0;
      r_readdata      <= '0;
      r_err_count     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_remaining     <= w_remaining_nxt;
      r_index         <= w_index_nxt;
      r_waitrequest   <= (w_state_nxt == S_RD_BURST);
      r_readdatavalid <= w_rd_issue;
      if (w_rd_issue) begin
        r_readdata <= r_mem[r_index];
      end
      if (w_err_inc && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  // RAM has no reset so its contents survive reset_n.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < DATA_BYTES; b++) begin
        if (byteenable[b]) begin
          r_mem[w_mem_idx][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

  assign waitrequest   = r_waitrequest;
  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_svm_mem_responder.sv
// Self-checking bench for svm_mem_responder: directed steps, read data checked
// against a reference RAM model through a scoreboard queue.
module tb_svm_mem_responder;

  localparam int unsigned AW = 48;
  localparam int unsigned DW = 512;
  localparam int unsigned BW = 5;
  localparam int unsigned DL = 10;
  localparam int unsigned DB = DW / 8;
  localparam int unsigned BS = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [BW-1:0] burstcount = '0;
  logic [DW-1:0] writedata = '0;
  logic [DB-1:0] byteenable = '0;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic [15:0]   err_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [1 << DL];
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  svm_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .MEM_DEPTH_LOG2(DL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .burstcount(burstcount), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every returned beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_beat", DW'(readdatavalid), '0);
      else                chk("readdata", readdata, sb.pop_front());
    end
  end

  task automatic write_burst(input logic [AW-1:0] addr, input int n,
                             input logic [DW-1:0] base, input logic [DB-1:0] be);
    logic [DL-1:0] idx;
    logic [DW-1:0] wd;
    idx = addr[BS +: DL];
    for (int b = 0; b < n; b++) begin
      wd         = base + DW'(b);
      write      = 1'b1;
      address    = (b == 0) ? addr : ~addr;
      burstcount = (b == 0) ? BW'(n) : '0;
      writedata  = wd;
      byteenable = be;
      chk("wr_waitrequest", DW'(waitrequest), '0);
      for (int k = 0; k < DB; k++) if (be[k]) model[idx][k*8 +: 8] = wd[k*8 +: 8];
      idx++;
      @(posedge clk); #1;
    end
    write = 1'b0;
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input int n);
    logic [DL-1:0] idx;
    idx = addr[BS +: DL];
    for (int k = 0; k < n; k++) begin
      sb.push_back(model[idx]);
      idx++;
    end
    read       = 1'b1;
    address    = addr;
    burstcount = BW'(n);
    chk("rd_accept_wait", DW'(waitrequest), '0);
    @(posedge clk); #1;
    read    = 1'b0;
    address = '0;
    for (int k = 0; k < n; k++) begin
      chk("rd_waitrequest", DW'(waitrequest), DW'(1'b1));
      chk("rd_valid", DW'(readdatavalid), DW'(k > 0));
      @(posedge clk); #1;
    end
    chk("rd_wait_release", DW'(waitrequest), '0);
    chk("rd_valid_last", DW'(readdatavalid), DW'(1'b1));
    @(posedge clk); #1;
    chk("rd_valid_end", DW'(readdatavalid), '0);
    chk("sb_drained", DW'(sb.size()), '0);
  endtask

  initial begin
    for (int i = 0; i < (1 << DL); i++) model[i] = '0;

    // Reset release
    repeat (5) @(posedge clk);
    #1;
    chk("rst_waitrequest", DW'(waitrequest), DW'(1'b1));
    chk("rst_rdvalid", DW'(readdatavalid), '0);
    chk("rst_err", DW'(err_count), '0);
    chk("rst_readdata", readdata, '0);
    reset_n = 1'b1;
    #1;
    chk("rel_wait_hold", DW'(waitrequest), DW'(1'b1));
    @(posedge clk); #1;
    chk("rel_wait_low", DW'(waitrequest), '0);

    // Burst write then read-after-write in the next cycle
    write_burst(48'h1000, 4, DW'(8'hA0), '1);
    read_burst(48'h1000, 4);

    // Index wrap within a burst; read through an aliased address
    write_burst(48'hFF80, 3, DW'(16'hB0B0), '1);
    read_burst(48'h1_0000_FF80, 3);

    // Byteenable merge
    write_burst(48'h4000, 1, '1, '1);
    write_burst(48'h4000, 1, '0, DB'(1));
    write_burst(48'h4000, 1, DW'(16'h1234), '0);
    read_burst(48'h4000, 1);

    // Protocol errors
    write_burst(48'h2000, 1, DW'(8'h55), '1);
    write_burst(48'h2040, 1, DW'(8'h66), '1);
    chk("err_none", DW'(err_count), '0);
    write = 1'b1; address = 48'h2000; burstcount = '0; writedata = DW'(16'hDEAD); byteenable = '1;
    @(posedge clk); #1;
    write = 1'b0;
    chk("err_bc0", DW'(err_count), DW'(16'd1));
    read = 1'b1; write = 1'b1; address = 48'h2040; burstcount = BW'(1); writedata = DW'(8'h77);
    model[10'h081] = DW'(8'h77);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    chk("err_rw", DW'(err_count), DW'(16'd2));
    chk("rw_no_rd_wait", DW'(waitrequest), '0);
    read_burst(48'h2000, 2);

    // Read asserted during a write burst
    write = 1'b1; address = 48'h2080; burstcount = BW'(2); writedata = DW'(8'h88);
    model[10'h082] = DW'(8'h88);
    @(posedge clk); #1;
    read = 1'b1; writedata = DW'(8'h89);
    model[10'h083] = DW'(8'h89);
    chk("wrb_wait", DW'(waitrequest), '0);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    chk("err_wrb_read", DW'(err_count), DW'(16'd3));
    read_burst(48'h2080, 2);

    // Saturation
    write = 1'b1; burstcount = '0;
    repeat (70000) @(posedge clk);
    #1;
    write = 1'b0;
    chk("err_sat", DW'(err_count), DW'(16'hFFFF));

    // Reset during a read burst
    write_burst(48'h3000, 8, DW'(8'hC0), '1);
    sb.push_back(model[10'h0C0]);
    sb.push_back(model[10'h0C1]);
    read = 1'b1; address = 48'h3000; burstcount = BW'(8);
    @(posedge clk); #1;
    read = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdvalid", DW'(readdatavalid), '0);
    chk("mid_rst_wait", DW'(waitrequest), DW'(1'b1));
    chk("mid_rst_err", DW'(err_count), '0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_rst_sb", DW'(sb.size()), '0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_wait", DW'(waitrequest), '0);
    read_burst(48'h3000, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
